// File: rtl/mouse_hit_detect.sv
// Registered box test of the cursor position against a rectangular target sprite.
// Define MOUSE_HIT_INPUT_REG_EN to add an input register stage (total latency 2 cycles).
module mouse_hit_detect #(
  parameter int unsigned TARGET_WIDTH  = 64,
  parameter int unsigned TARGET_HEIGHT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] mouse_x,
  input  logic [9:0] mouse_y,
  input  logic [9:0] target_x,
  input  logic [9:0] target_y,
  output logic       mouse_on_target
);

  localparam logic [10:0] W_EXT = 11'(TARGET_WIDTH);
  localparam logic [10:0] H_EXT = 11'(TARGET_HEIGHT);

  logic [9:0]  w_mouse_x;
  logic [9:0]  w_mouse_y;
  logic [9:0]  w_target_x;
  logic [9:0]  w_target_y;
  logic [10:0] w_x_end;
  logic [10:0] w_y_end;
  logic        w_hit_x;
  logic        w_hit_y;
  logic        r_hit;

`ifdef MOUSE_HIT_INPUT_REG_EN
  logic [9:0] r_mouse_x;
  logic [9:0] r_mouse_y;
  logic [9:0] r_target_x;
  logic [9:0] r_target_y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mouse_x  <= '0;
      r_mouse_y  <= '0;
      r_target_x <= '0;
      r_target_y <= '0;
    end else begin
      r_mouse_x  <= mouse_x;
      r_mouse_y  <= mouse_y;
      r_target_x <= target_x;
      r_target_y <= target_y;
    end
  end

  assign w_mouse_x  = r_mouse_x;
  assign w_mouse_y  = r_mouse_y;
  assign w_target_x = r_target_x;
  assign w_target_y = r_target_y;
`else
  assign w_mouse_x  = mouse_x;
  assign w_mouse_y  = mouse_y;
  assign w_target_x = target_x;
  assign w_target_y = target_y;
`endif

  // 11-bit sums: a target running past 1023 simply clips, it never wraps to 0.
  assign w_x_end = {1'b0, w_target_x} + W_EXT;
  assign w_y_end = {1'b0, w_target_y} + H_EXT;

  assign w_hit_x = (w_mouse_x >= w_target_x) && ({1'b0, w_mouse_x} < w_x_end);
  assign w_hit_y = (w_mouse_y >= w_target_y) && ({1'b0, w_mouse_y} < w_y_end);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit <= 1'b0;
    end else begin
      r_hit <= w_hit_x && w_hit_y;
    end
  end

  assign mouse_on_target = r_hit;

endmodule

// File: tb/tb_mouse_hit_detect.sv
// Self-checking bench for mouse_hit_detect: vector table, corner sequences, windowed raster
// sweep and biased random stimulus against an integer box model.
module tb_mouse_hit_detect;

  localparam int TW = 64;
  localparam int TH = 64;
`ifdef MOUSE_HIT_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] mouse_x = '0;
  logic [9:0] mouse_y = '0;
  logic [9:0] target_x = 10'd500;
  logic [9:0] target_y = 10'd500;
  logic       mouse_on_target;

  int checks = 0;
  int errors = 0;

  mouse_hit_detect #(
    .TARGET_WIDTH (TW),
    .TARGET_HEIGHT(TH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mouse_x        (mouse_x),
    .mouse_y        (mouse_y),
    .target_x       (target_x),
    .target_y       (target_y),
    .mouse_on_target(mouse_on_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mx;
    int my;
    int tx;
    int ty;
    bit exp;
  } vec_t;

  // Reference: plain integer rectangle test, screen limited to 0..1023.
  function automatic bit model(int mx, int my, int tx, int ty);
    return (mx >= tx) && (mx < tx + TW) && (my >= ty) && (my < ty + TH);
  endfunction

  task automatic check(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int mx, int my, int tx, int ty);
    mouse_x  = 10'(mx);
    mouse_y  = 10'(my);
    target_x = 10'(tx);
    target_y = 10'(ty);
  endtask

  vec_t vecs[$];
  bit   exp_q[$];
  int   hits;
  int   mx;
  int   my;
  int   tx;
  int   ty;

  // Push one point into the stream; compare once the pipeline has filled.
  task automatic stream(string name, int smx, int smy, int stx, int sty);
    bit e;
    drive(smx, smy, stx, sty);
    exp_q.push_back(model(smx, smy, stx, sty));
    tick();
    if (exp_q.size() == LAT) begin
      e = exp_q.pop_front();
      if (mouse_on_target === 1'b1) hits++;
      check(name, mouse_on_target, e);
    end
  endtask

  initial begin
    // Reset held with the cursor on the target: output stays low.
    drive(500, 500, 500, 500);
    #2;
    check("reset_async", mouse_on_target, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_hold", mouse_on_target, 1'b0);
    end
    rst = 1'b0;
    repeat (LAT) tick();
    check("reset_release", mouse_on_target, 1'b1);

    // Corners and no-wrap vectors.
    vecs.push_back('{500, 500, 500, 500, 1'b1});
    vecs.push_back('{563, 563, 500, 500, 1'b1});
    vecs.push_back('{564, 500, 500, 500, 1'b0});
    vecs.push_back('{500, 564, 500, 500, 1'b0});
    vecs.push_back('{499, 500, 500, 500, 1'b0});
    vecs.push_back('{500, 499, 500, 500, 1'b0});
    vecs.push_back('{563, 500, 500, 500, 1'b1});
    vecs.push_back('{10, 520, 1000, 500, 1'b0});
    vecs.push_back('{1023, 520, 1000, 500, 1'b1});
    vecs.push_back('{1000, 520, 1000, 500, 1'b1});
    vecs.push_back('{999, 520, 1000, 500, 1'b0});
    vecs.push_back('{520, 5, 500, 1000, 1'b0});
    vecs.push_back('{520, 1023, 500, 1000, 1'b1});
    vecs.push_back('{0, 0, 0, 0, 1'b1});
    vecs.push_back('{64, 0, 0, 0, 1'b0});
    foreach (vecs[i]) begin
      drive(vecs[i].mx, vecs[i].my, vecs[i].tx, vecs[i].ty);
      repeat (LAT) tick();
      check($sformatf("vec%0d", i), mouse_on_target, vecs[i].exp);
    end

    // Mid-operation reset lands between edges and clears the output at once.
    drive(520, 520, 500, 500);
    repeat (LAT) tick();
    check("midrst_pre", mouse_on_target, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_async", mouse_on_target, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (LAT) tick();
    check("midrst_recover", mouse_on_target, 1'b1);

    // Target moves away from a stationary cursor.
    drive(520, 520, 500, 500);
    repeat (LAT) tick();
    drive(520, 520, 600, 500);
    check("move_before", mouse_on_target, 1'b1);
    repeat (LAT) tick();
    check("move_after", mouse_on_target, 1'b0);

    // Windowed raster sweep around the target, one point per clock.
    exp_q.delete();
    hits = 0;
    for (int y = 480; y < 584; y++) begin
      for (int x = 480; x < 584; x++) begin
        stream("sweep", x, y, 500, 500);
      end
    end
    repeat (LAT - 1) begin
      tick();
      if (mouse_on_target === 1'b1) hits++;
      check("sweep_tail", mouse_on_target, exp_q.pop_front());
    end
    checks++;
    if (hits != TW * TH) begin
      errors++;
      $display("FAIL sweep_hits: got %0d expected %0d", hits, TW * TH);
    end

    // Random cursor and target, cursor biased near the target so both outcomes occur.
    exp_q.delete();
    for (int i = 0; i < 3000; i++) begin
      tx = int'($urandom_range(1023));
      ty = int'($urandom_range(1023));
      if ($urandom_range(3) == 0) begin
        mx = int'($urandom_range(1023));
        my = int'($urandom_range(1023));
      end else begin
        mx = tx + int'($urandom_range(150)) - 40;
        my = ty + int'($urandom_range(150)) - 40;
        if (mx < 0) mx = 0;
        if (my < 0) my = 0;
        if (mx > 1023) mx = 1023;
        if (my > 1023) my = 1023;
      end
      stream("random", mx, my, tx, ty);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
